// File: rtl/fifo_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_ctrl -- pointer/flag controller for a single-clock FIFO.
//
// Drives an external DEPTH-entry storage array. It owns the read and write
// pointers, the occupancy count, the status flags and the sticky error flags.
// The storage itself is outside this block.
//
// Ports
//   clk, rst_n        : clock; asynchronous active-low reset
//   push, pop         : requests to write or read one entry this cycle
//   clr_err           : synchronous clear of overflow/underflow
//   mem_wr_en/addr    : storage write strobe and address (same cycle as push)
//   mem_rd_en/addr    : storage read strobe and address (same cycle as pop)
//   rd_valid          : storage dout holds the popped entry this cycle
//   full, empty       : pointer-derived occupancy flags
//   almost_full/empty : count-derived level flags (AF_LEVEL / AE_LEVEL)
//   count             : stored entries, 0..DEPTH
//   overflow/underflow: sticky flags for a rejected push or pop
// ----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [AW-1:0] mem_rd_addr,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q,  count_d;
    logic        rd_valid_q;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;

    logic        wr_acc, rd_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Strobes are gated by rst_n so storage is never touched while reset is
    // held, independent of what the requester is driving.
    assign wr_acc = push & ~full  & rst_n;
    assign rd_acc = pop  & ~empty & rst_n;

    assign mem_wr_en   = wr_acc;
    assign mem_rd_en   = rd_acc;
    assign mem_wr_addr = wr_ptr_q[AW-1:0];
    assign mem_rd_addr = rd_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

        // Simultaneous accepted push and pop leaves occupancy unchanged.
        if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
        else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

        // A new error in the same cycle as clr_err keeps the flag set.
        ovf_d = (push & full)  | (ovf_q & ~clr_err);
        udf_d = (pop  & empty) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign count        = count_q;
    assign rd_valid     = rd_valid_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

    // The separate counter must track the pointer difference exactly.
    a_count_matches_ptrs: assert property (
        @(posedge clk) disable iff (!rst_n)
        count_q == (wr_ptr_q - rd_ptr_q)
    );

    a_count_in_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        count_q <= (AW+1)'(DEPTH)
    );

endmodule
